// File: rtl/lcd_fb_arbiter_if.sv
// lcd_fb_arbiter_if
//   Bundles the two PPU pixel streams, the shared frame-buffer write port and
//   the per-screen status outputs of lcd_fb_arbiter.
//   master : pixel sources / RAM side (drives strobes, data, mode, on, wr_ready)
//   slave  : the arbiter (drives wr_en/addr/data, frame_done, ovf, drop_cnt)
// Parameters: DW pixel word width, AW write address width.
interface lcd_fb_arbiter_if #(
  parameter int unsigned DW = 15,
  parameter int unsigned AW = 16
);
  logic          clkena1;
  logic          clkena2;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic [1:0]    mode1;
  logic [1:0]    mode2;
  logic          on1;
  logic          on2;
  logic          wr_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_done1;
  logic          frame_done2;
  logic          ovf1;
  logic          ovf2;
  logic [7:0]    drop_cnt1;
  logic [7:0]    drop_cnt2;

  modport master (
    output clkena1, clkena2, data1, data2, mode1, mode2, on1, on2, wr_ready,
    input  wr_en, wr_addr, wr_data, frame_done1, frame_done2,
    input  ovf1, ovf2, drop_cnt1, drop_cnt2
  );

  modport slave (
    input  clkena1, clkena2, data1, data2, mode1, mode2, on1, on2, wr_ready,
    output wr_en, wr_addr, wr_data, frame_done1, frame_done2,
    output ovf1, ovf2, drop_cnt1, drop_cnt2
  );
endinterface

// File: rtl/lcd_fb_arbiter.sv
// lcd_fb_arbiter
//   Merges the two PPU pixel streams onto one registered frame-buffer write
//   port. Each stream has a small FIFO of {first, data} entries; a round-robin
//   arbiter pops one entry per cycle while wr_ready is high. Screen 1 is
//   written from word 0, screen 2 from word FRAME_PIXELS.
// Ports:
//   clk    core clock, rising edge
//   reset  synchronous, active-high
//   bus    lcd_fb_arbiter_if.slave: pixel inputs (clkenaN, dataN, modeN, onN),
//          wr_ready, registered write port (wr_en, wr_addr, wr_data),
//          frame_doneN pulses, sticky ovfN, drop_cntN
// Build option:
//   LCD_ARB_STATS_EN  when defined, drop_cntN count dropped pixels
//                     (saturating at 255); otherwise they read 0.
module lcd_fb_arbiter #(
  parameter int unsigned DW           = 15,
  parameter int unsigned AW           = 16,
  parameter int unsigned FRAME_PIXELS = 23040,
  parameter int unsigned FIFO_LG      = 2
) (
  input  logic           clk,
  input  logic           reset,
  lcd_fb_arbiter_if.slave bus
);

  localparam int unsigned    DEPTH    = 1 << FIFO_LG;
  localparam int unsigned    OW       = 15;
  localparam logic [OW-1:0]  FP_OFF   = OW'(FRAME_PIXELS);
  localparam logic [OW-1:0]  LAST_OFF = OW'(FRAME_PIXELS - 1);
  localparam logic [AW-1:0]  BASE2    = AW'(FRAME_PIXELS);
  localparam logic [FIFO_LG:0] DEPTH_C = (FIFO_LG + 1)'(DEPTH);

  // Last requester granted; the other one wins a tie.
  typedef enum logic {REQ1 = 1'b0, REQ2 = 1'b1} req_e;

  logic          w_stb    [2];
  logic [DW-1:0] w_din    [2];
  logic          w_vblank [2];
  logic          w_on     [2];

  assign w_stb[0]    = bus.clkena1;
  assign w_stb[1]    = bus.clkena2;
  assign w_din[0]    = bus.data1;
  assign w_din[1]    = bus.data2;
  assign w_vblank[0] = (bus.mode1 == 2'b01);
  assign w_vblank[1] = (bus.mode2 == 2'b01);
  assign w_on[0]     = bus.on1;
  assign w_on[1]     = bus.on2;

  logic [DW:0]        r_mem     [2][DEPTH];
  logic [FIFO_LG-1:0] r_wp      [2];
  logic [FIFO_LG-1:0] r_rp      [2];
  logic [FIFO_LG:0]   r_cnt     [2];
  logic               r_restart [2];
  logic [OW-1:0]      r_off     [2];
  logic               r_ovf     [2];
  req_e               r_last;
  req_e               w_last_nxt;

  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic          r_fd1;
  logic          r_fd2;

  logic          w_empty     [2];
  logic          w_full      [2];
  logic          w_grant     [2];
  logic          w_push      [2];
  logic          w_drop      [2];
  logic          w_first_tag [2];
  logic          w_overrun   [2];
  logic          w_write     [2];
  logic [DW:0]   w_head      [2];
  logic [OW-1:0] w_woff      [2];
  logic [AW-1:0] w_waddr     [2];

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      w_empty[i] = (r_cnt[i] == '0);
      w_full[i]  = (r_cnt[i] == DEPTH_C);
      w_head[i]  = r_mem[i][r_rp[i]];
    end

    w_grant[0] = bus.wr_ready && !w_empty[0] && (w_empty[1] || (r_last == REQ2));
    w_grant[1] = bus.wr_ready && !w_empty[1] && (w_empty[0] || (r_last == REQ1));

    w_last_nxt = r_last;
    if (w_grant[0]) begin
      w_last_nxt = REQ1;
    end else if (w_grant[1]) begin
      w_last_nxt = REQ2;
    end

    for (int unsigned i = 0; i < 2; i++) begin
      // A full FIFO still accepts when its head leaves in the same cycle.
      w_push[i]      = w_on[i] && w_stb[i] && (!w_full[i] || w_grant[i]);
      w_drop[i]      = w_on[i] && w_stb[i] && w_full[i] && !w_grant[i];
      w_first_tag[i] = r_restart[i] || w_vblank[i];
      // Overrun pops are consumed without writing.
      w_overrun[i]   = w_grant[i] && !w_head[i][DW] && (r_off[i] >= FP_OFF);
      w_write[i]     = w_grant[i] && !w_overrun[i];
      w_woff[i]      = w_head[i][DW] ? '0 : r_off[i];
    end

    w_waddr[0] = AW'(w_woff[0]);
    w_waddr[1] = BASE2 + AW'(w_woff[1]);
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wp[i]] <= {w_first_tag[i], w_din[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_wp[i]      <= '0;
        r_rp[i]      <= '0;
        r_cnt[i]     <= '0;
        r_restart[i] <= 1'b1;
        r_off[i]     <= '0;
        r_ovf[i]     <= 1'b0;
      end
      r_last    <= REQ2;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_fd1     <= 1'b0;
      r_fd2     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (!w_on[i]) begin
          // Disabled LCD: flush and rewind; an entry popped this cycle
          // still completes its write below.
          r_wp[i]  <= '0;
          r_rp[i]  <= '0;
          r_cnt[i] <= '0;
          r_off[i] <= '0;
        end else begin
          if (w_push[i])  r_wp[i] <= r_wp[i] + 1'b1;
          if (w_grant[i]) r_rp[i] <= r_rp[i] + 1'b1;
          r_cnt[i] <= r_cnt[i] + {{FIFO_LG{1'b0}}, w_push[i]}
                               - {{FIFO_LG{1'b0}}, w_grant[i]};
          if (w_write[i]) r_off[i] <= w_woff[i] + 1'b1;
        end

        if (w_vblank[i] || !w_on[i]) begin
          r_restart[i] <= 1'b1;
        end else if (w_push[i]) begin
          r_restart[i] <= 1'b0;
        end

        if (w_drop[i] || w_overrun[i]) r_ovf[i] <= 1'b1;
      end

      r_last  <= w_last_nxt;
      r_wr_en <= w_write[0] || w_write[1];
      r_fd1   <= w_write[0] && (w_woff[0] == LAST_OFF);
      r_fd2   <= w_write[1] && (w_woff[1] == LAST_OFF);
      if (w_write[0]) begin
        r_wr_addr <= w_waddr[0];
        r_wr_data <= w_head[0][DW-1:0];
      end else if (w_write[1]) begin
        r_wr_addr <= w_waddr[1];
        r_wr_data <= w_head[1][DW-1:0];
      end
    end
  end

  assign bus.wr_en       = r_wr_en;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.wr_data     = r_wr_data;
  assign bus.frame_done1 = r_fd1;
  assign bus.frame_done2 = r_fd2;
  assign bus.ovf1        = r_ovf[0];
  assign bus.ovf2        = r_ovf[1];

`ifdef LCD_ARB_STATS_EN
  logic [7:0] r_drop_cnt [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_drop_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if ((w_drop[i] || w_overrun[i]) && (r_drop_cnt[i] != '1)) begin
          r_drop_cnt[i] <= r_drop_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign bus.drop_cnt1 = r_drop_cnt[0];
  assign bus.drop_cnt2 = r_drop_cnt[1];
`else
  assign bus.drop_cnt1 = '0;
  assign bus.drop_cnt2 = '0;
`endif

endmodule
